// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared widths, encodings and payload types for the load/store memory controller.
// Optional misalignment trap is enabled by defining YSYX_23060251_MISALIGN_CHK_EN.
package lsu_mem_ctrl_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Memory request payload as held on the mem_* bus.
    typedef struct packed {
        logic              wen;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: dword address, store lane shift and strobes,
// and load data extraction with sign/zero extension.
module lsu_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [1:0]        req_size,
    output logic [XLEN-1:0]   mem_addr_c,
    output logic [XLEN-1:0]   mem_wdata_c,
    output logic [STRB_W-1:0] mem_wstrb_c,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data_c
);

    logic [STRB_W-1:0] size_mask;
    logic [XLEN-1:0]   ld_shift;

    // Store side: lanes beyond bit 63 / strobe bit 7 fall off the end.
    always_comb begin
        size_mask = 8'h01;
        case (req_size)
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        mem_addr_c  = {req_addr[XLEN-1:OFF_W], OFF_W'(0)};
        mem_wdata_c = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
        mem_wstrb_c = req_wen ? (size_mask << req_addr[OFF_W-1:0]) : '0;
    end

    // Load side: move the addressed bytes to lane 0, then extend.
    always_comb begin
        ld_shift  = ld_rdata >> {ld_off, 3'b000};
        ld_data_c = ld_shift;
        case (ld_size)
            SIZE_B:  ld_data_c = {{(XLEN-8){ld_signed & ld_shift[7]}}, ld_shift[7:0]};
            SIZE_H:  ld_data_c = {{(XLEN-16){ld_signed & ld_shift[15]}}, ld_shift[15:0]};
            SIZE_W:  ld_data_c = {{(XLEN-32){ld_signed & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data_c = ld_shift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one outstanding op, IDLE/REQ/WAIT/DONE handshake FSM.
// Define YSYX_23060251_MISALIGN_CHK_EN to trap misaligned ops with err_o instead of issuing them.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              wen_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [1:0]        size_i,
    input  logic              is_signed_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic              err_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_wen_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic              mem_resp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    state_e            state;
    mem_req_t          mem_req;
    logic [OFF_W-1:0]  ld_off;
    logic [1:0]        ld_size;
    logic              ld_signed;

    logic [XLEN-1:0]   mem_addr_c;
    logic [XLEN-1:0]   mem_wdata_c;
    logic [STRB_W-1:0] mem_wstrb_c;
    logic [XLEN-1:0]   ld_data_c;

    lsu_align u_align (
        .req_wen     (wen_i),
        .req_addr    (addr_i),
        .req_wdata   (wdata_i),
        .req_size    (size_i),
        .mem_addr_c  (mem_addr_c),
        .mem_wdata_c (mem_wdata_c),
        .mem_wstrb_c (mem_wstrb_c),
        .ld_off      (ld_off),
        .ld_size     (ld_size),
        .ld_signed   (ld_signed),
        .ld_rdata    (mem_rdata_i),
        .ld_data_c   (ld_data_c)
    );

    assign mem_wen_o   = mem_req.wen;
    assign mem_addr_o  = mem_req.addr;
    assign mem_wdata_o = mem_req.wdata;
    assign mem_wstrb_o = mem_req.wstrb;

    // Request lanes are formed at accept time so the mem_* bus is a plain register in REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            in_ready_o      <= 1'b1;
            out_valid_o     <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req         <= '0;
            rdata_o         <= '0;
            err_o           <= 1'b0;
            ld_off          <= '0;
            ld_size         <= '0;
            ld_signed       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        in_ready_o    <= 1'b0;
                        ld_off        <= addr_i[OFF_W-1:0];
                        ld_size       <= size_i;
                        ld_signed     <= is_signed_i;
                        mem_req.wen   <= wen_i;
                        mem_req.addr  <= mem_addr_c;
                        mem_req.wdata <= mem_wdata_c;
                        mem_req.wstrb <= mem_wstrb_c;
`ifdef YSYX_23060251_MISALIGN_CHK_EN
                        if (is_misaligned(addr_i[OFF_W-1:0], size_i)) begin
                            state       <= ST_DONE;
                            out_valid_o <= 1'b1;
                            err_o       <= 1'b1;
                            rdata_o     <= '0;
                        end else
`endif
                        begin
                            state           <= ST_REQ;
                            mem_req_valid_o <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid_i) begin
                        state       <= ST_DONE;
                        out_valid_o <= 1'b1;
                        err_o       <= 1'b0;
                        rdata_o     <= mem_req.wen ? '0 : ld_data_c;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed ops push expected mem requests and results,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_lsu_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        wen_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  size_i;
    logic        is_signed_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] rdata_o;
    logic        err_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_wen_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_rdata_i;

    lsu_mem_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .wen_i            (wen_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .size_i           (size_i),
        .is_signed_i      (is_signed_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .rdata_o          (rdata_o),
        .err_o            (err_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_wen_o        (mem_wen_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wstrb_o      (mem_wstrb_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_exp_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } out_exp_t;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] rdata;
        int          req_delay;
        int          out_delay;
        bit          stray;
        logic        exp_err;
        logic [63:0] exp_maddr;
        logic [63:0] exp_mwdata;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_rdata;
    } vec_t;

    req_exp_t exp_req_q[$];
    out_exp_t exp_out_q[$];
    vec_t     vecs[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on handshakes, checks bus stability while stalled.
    logic       prev_req_stall = 1'b0;
    logic       prev_out_stall = 1'b0;
    req_exp_t   prev_req;
    out_exp_t   prev_out;
    always @(negedge clk_i) begin
        req_exp_t cur_req;
        out_exp_t cur_out;
        req_exp_t e_req;
        out_exp_t e_out;
        cur_req = {mem_wen_o, mem_addr_o, mem_wdata_o, mem_wstrb_o};
        cur_out = {rdata_o, err_o};
        if (rst_i) begin
            prev_req_stall = 1'b0;
            prev_out_stall = 1'b0;
        end else begin
            if (mem_req_valid_o && prev_req_stall)
                check("mem_req_stable", 192'(cur_req), 192'(prev_req));
            if (out_valid_o && prev_out_stall)
                check("out_stable", 192'(cur_out), 192'(prev_out));
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_req_unexpected actual=%0h required=none", cur_req);
                end else begin
                    e_req = exp_req_q.pop_front();
                    check("mem_wen",   192'(mem_wen_o),   192'(e_req.wen));
                    check("mem_addr",  192'(mem_addr_o),  192'(e_req.addr));
                    check("mem_wdata", 192'(mem_wdata_o), 192'(e_req.wdata));
                    check("mem_wstrb", 192'(mem_wstrb_o), 192'(e_req.wstrb));
                end
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%0h required=none", cur_out);
                end else begin
                    e_out = exp_out_q.pop_front();
                    check("rdata", 192'(rdata_o), 192'(e_out.rdata));
                    check("err",   192'(err_o),   192'(e_out.err));
                end
            end
            prev_req_stall = mem_req_valid_o && !mem_req_ready_i;
            prev_out_stall = out_valid_o && !out_ready_i;
        end
        prev_req = cur_req;
        prev_out = cur_out;
    end

    task automatic clear_inputs();
        in_valid_i  = 1'b0;
        wen_i       = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        size_i      = '0;
        is_signed_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        req_exp_t re;
        out_exp_t oe;
        re = {v.wen, v.exp_maddr, v.exp_mwdata, v.exp_wstrb};
        oe = {v.exp_rdata, v.exp_err};
        if (!v.exp_err) exp_req_q.push_back(re);
        exp_out_q.push_back(oe);
        check("in_ready_idle", 192'(in_ready_o), 192'(1));
        in_valid_i  = 1'b1;
        wen_i       = v.wen;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        size_i      = v.size;
        is_signed_i = v.sgn;
        step();
        clear_inputs();
        check("in_ready_busy", 192'(in_ready_o), 192'(0));
        if (!v.exp_err) begin
            check("req_valid_cycle1", 192'(mem_req_valid_o), 192'(1));
            for (int i = 0; i < v.req_delay; i++) begin
                if (v.stray) begin
                    mem_resp_valid_i = 1'b1;
                    mem_rdata_i      = 64'hBAD0_BAD0_BAD0_BAD0;
                end
                step();
                check("req_hold", 192'(mem_req_valid_o), 192'(1));
            end
            mem_req_ready_i = 1'b1;
            if (v.stray) begin
                mem_resp_valid_i = 1'b1;
                mem_rdata_i      = 64'hBAD1_BAD1_BAD1_BAD1;
            end else begin
                mem_resp_valid_i = 1'b0;
            end
            step();
            mem_req_ready_i = 1'b0;
            check("req_drop", 192'(mem_req_valid_o), 192'(0));
            check("out_not_early", 192'(out_valid_o), 192'(0));
            mem_resp_valid_i = 1'b1;
            mem_rdata_i      = v.rdata;
            step();
            mem_resp_valid_i = 1'b0;
            mem_rdata_i      = '0;
        end else begin
            check("req_none", 192'(mem_req_valid_o), 192'(0));
        end
        check("out_valid_latency", 192'(out_valid_o), 192'(1));
        for (int i = 0; i < v.out_delay; i++) begin
            check("done_in_ready", 192'(in_ready_o), 192'(0));
            check("done_no_req", 192'(mem_req_valid_o), 192'(0));
            step();
            check("done_hold", 192'(out_valid_o), 192'(1));
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("out_valid_clr", 192'(out_valid_o), 192'(0));
        check("in_ready_back", 192'(in_ready_o), 192'(1));
    endtask

    function automatic vec_t mk(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input logic sgn, input logic [63:0] rdata,
                                input int rd, input int od, input bit stray, input logic err,
                                input logic [63:0] maddr, input logic [63:0] mwdata,
                                input logic [7:0] wstrb, input logic [63:0] exp_rdata);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn;
        v.rdata = rdata; v.req_delay = rd; v.out_delay = od; v.stray = stray;
        v.exp_err = err; v.exp_maddr = maddr; v.exp_mwdata = mwdata;
        v.exp_wstrb = wstrb; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_i            = 1'b1;
        out_ready_i      = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = '0;
        clear_inputs();
        repeat (3) step();
        rst_i = 1'b0;
        check("rst_in_ready",  192'(in_ready_o),      192'(1));
        check("rst_out_valid", 192'(out_valid_o),     192'(0));
        check("rst_req_valid", 192'(mem_req_valid_o), 192'(0));
        check("rst_rdata",     192'(rdata_o),         192'(0));
        check("rst_err",       192'(err_o),           192'(0));

        //        wen  addr              wdata                  sz sg rdata                  rd od st err maddr             mwdata                 wstrb  exp_rdata
        vecs.push_back(mk(0, 64'h8000_0003, 64'h0, 2'd0, 1, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80));
        vecs.push_back(mk(1, 64'h8000_0006, 64'hABCD, 2'd1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 0, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0));
        vecs.push_back(mk(0, 64'h8000_0008, 64'h0, 2'd3, 0, 64'h8123_4567_89AB_CDEF, 5, 0, 1, 0, 64'h8000_0008, 64'h0, 8'h00, 64'h8123_4567_89AB_CDEF));
        vecs.push_back(mk(0, 64'h0000_1002, 64'h0, 2'd1, 1, 64'h0000_0000_F00D_0000, 0, 3, 0, 0, 64'h0000_1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D));
        vecs.push_back(mk(0, 64'h0000_1004, 64'h0, 2'd2, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 0, 64'h0000_1000, 64'h0, 8'h00, 64'h0000_0000_8765_4321));
        vecs.push_back(mk(0, 64'h0000_1004, 64'h0, 2'd2, 1, 64'h8765_4321_0000_0000, 1, 1, 0, 0, 64'h0000_1000, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321));
        vecs.push_back(mk(1, 64'h0000_2005, 64'hFFFF_FFFF_FFFF_FF5A, 2'd0, 0, 64'h0, 0, 0, 0, 0, 64'h0000_2000, 64'hFFFF_5A00_0000_0000, 8'h20, 64'h0));
        vecs.push_back(mk(1, 64'h0000_2004, 64'h1234_5678, 2'd2, 0, 64'h0, 2, 0, 0, 0, 64'h0000_2000, 64'h1234_5678_0000_0000, 8'hF0, 64'h0));
        vecs.push_back(mk(1, 64'h0000_2000, 64'h0102_0304_0506_0708, 2'd3, 0, 64'h0, 0, 0, 0, 0, 64'h0000_2000, 64'h0102_0304_0506_0708, 8'hFF, 64'h0));
        vecs.push_back(mk(0, 64'h0000_3000, 64'h0, 2'd0, 0, 64'h0000_0000_0000_00FF, 0, 0, 0, 0, 64'h0000_3000, 64'h0, 8'h00, 64'h0000_0000_0000_00FF));
`ifdef YSYX_23060251_MISALIGN_CHK_EN
        vecs.push_back(mk(0, 64'h8000_0002, 64'h0, 2'd2, 0, 64'h1122_3344_5566_7788, 0, 0, 0, 1, 64'h0, 64'h0, 8'h00, 64'h0));
        vecs.push_back(mk(1, 64'h0000_2006, 64'hAABB_CCDD, 2'd2, 0, 64'h0, 0, 2, 0, 1, 64'h0, 64'h0, 8'h00, 64'h0));
`else
        vecs.push_back(mk(0, 64'h8000_0002, 64'h0, 2'd2, 0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_3344_5566));
        vecs.push_back(mk(1, 64'h0000_2006, 64'hAABB_CCDD, 2'd2, 0, 64'h0, 0, 2, 0, 0, 64'h0000_2000, 64'hCCDD_0000_0000_0000, 8'hC0, 64'h0));
`endif

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset while waiting for the response: op is dropped, late response ignored.
        exp_req_q.push_back({1'b0, 64'h0000_4000, 64'h0, 8'h00});
        in_valid_i = 1'b1;
        addr_i     = 64'h0000_4000;
        size_i     = 2'd3;
        step();
        clear_inputs();
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("wait_rst_in_ready",  192'(in_ready_o),  192'(1));
        check("wait_rst_out_valid", 192'(out_valid_o), 192'(0));
        check("wait_rst_rdata",     192'(rdata_o),     192'(0));
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 64'h5555_AAAA_5555_AAAA;
        step();
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = '0;
        for (int i = 0; i < 2; i++) begin
            check("stray_out_valid", 192'(out_valid_o),     192'(0));
            check("stray_in_ready",  192'(in_ready_o),      192'(1));
            check("stray_req_valid", 192'(mem_req_valid_o), 192'(0));
            step();
        end

        run_op(mk(0, 64'h0000_3001, 64'h0, 2'd0, 1, 64'h0000_0000_0000_7F00, 0, 0, 0, 0,
                  64'h0000_3000, 64'h0, 8'h00, 64'h0000_0000_0000_007F));

        step();
        check("req_queue_empty", 192'(exp_req_q.size()), 192'(0));
        check("out_queue_empty", 192'(exp_out_q.size()), 192'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
